// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types, including the multiplier FSM state encoding
package alu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;
endpackage

// File: rtl/adder.sv
// adder: WIDTH-bit adder (i_1 + i_2, optional invert of i_2 with carry-in) with carry-out, zero and signed-overflow flags
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic             invert_i_2,
  input  logic             enable,
  output logic [WIDTH-1:0] sum,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             exception_flag
);
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   r;
  always_comb begin
    b              = invert_i_2 ? ~i_2 : i_2;
    r              = enable ? {1'b0, i_1} + {1'b0, b} + {{WIDTH{1'b0}}, invert_i_2} : '0;
    sum            = r[WIDTH-1:0];
    overflow_flag  = r[WIDTH];
    zero_flag      = ~|sum;
    exception_flag = enable & (i_1[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != i_1[WIDTH-1]);
  end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative unsigned shift-and-add multiplier; op_a*op_b via in_valid/in_ready, product+flags via out_valid/out_ready
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               zero_flag,
  output logic               overflow_flag
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  mul_state_t       state, state_nx;
  logic [WIDTH-1:0] mcand, hi, lo, sum;
  logic [CW-1:0]    cnt;
  logic             c;
  adder #(.WIDTH(WIDTH)) u_adder (
    .i_1           (hi),
    .i_2           (mcand),
    .invert_i_2    (1'b0),
    .enable        (1'b1),
    .sum           (sum),
    .overflow_flag (c),
    .zero_flag     (),
    .exception_flag()
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE && in_valid)    ? CALC :
               (state == CALC && cnt == LAST) ? DONE :
               (state == DONE && out_ready)   ? IDLE : state;
    in_ready      = state == IDLE;
    out_valid     = state == DONE;
    product       = {hi, lo};
    zero_flag     = ~|product;
    overflow_flag = |hi;
  end
  // the carry-out lands in hi's MSB as the pair shifts right, so nothing is truncated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      mcand <= op_a;
      lo    <= op_b;
      hi    <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      {hi, lo} <= lo[0] ? {c, sum, lo[WIDTH-1:1]} : {1'b0, hi, lo[WIDTH-1:1]};
      cnt      <= cnt + 1'b1;
    end
endmodule
